// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - frame constants and types shared by the ADC SPI responder
package adc_pkg;

    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_ADDR_W     = 3;
    localparam int ADC_ADDR_FIRST = 2;
    localparam int ADC_LEAD_ZEROS = 4;
    localparam int ADC_CNT_W      = $clog2(ADC_FRAME_BITS);

    typedef logic [11:0] adc_sample_t;
    typedef logic [ADC_ADDR_W-1:0] adc_addr_t;

endpackage

// File: rtl/pin_sync_edge.sv
// rtl/pin_sync_edge.sv - pin synchronizer with registered rise/fall detect
// Ports: clk/rst (sync, active-high); pin (async input);
//        level (synchronized value, delayed to line up with rise/fall);
//        rise/fall (one-cycle pulses, SYNC_STAGES+1 cycles after the pin edge).
module pin_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    // level is the synchronized value one cycle late, so that in the cycle a
    // rise/fall pulse is high, level already shows the post-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            level  <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            level  <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~level;
            fall   <= ~sync_q[SYNC_STAGES-1] & level;
        end
    end

endmodule

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI responder model of an 8-channel 12-bit serial ADC
// Ports: c50m/rst (system clock, sync active-high reset);
//        sclk_in/cs_n_in/din_in (async controller pins);
//        sample_data (per-channel value returned, c50m domain);
//        dout (responder data); addr_latched (address of last completed frame);
//        frame_done/frame_abort (one-cycle pulses).
module adc_spi_responder
    import adc_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           c50m,
    input  logic                           rst,
    input  logic                           sclk_in,
    input  logic                           cs_n_in,
    input  logic                           din_in,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  sample_data,
    output logic                           dout,
    output adc_addr_t                      addr_latched,
    output logic                           frame_done,
    output logic                           frame_abort
);

    logic sclk_rise, sclk_fall, sclk_level;
    logic cs_n, cs_fall, cs_rise;
    logic din, din_rise, din_fall;

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(c50m), .rst(rst), .pin(sclk_in),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    // Idles high so a chip select tied low still produces one cs_fall after reset.
    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_n (
        .clk(c50m), .rst(rst), .pin(cs_n_in),
        .level(cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
        .clk(c50m), .rst(rst), .pin(din_in),
        .level(din), .rise(din_rise), .fall(din_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_level, cs_rise, din_rise, din_fall};

    logic [ADC_CNT_W-1:0]      bit_cnt;
    logic [ADC_CNT_W-1:0]      cnt_eff;
    logic [ADC_CNT_W-1:0]      tx_idx;
    logic [ADC_FRAME_BITS-1:0] tx_word;
    adc_addr_t                 addr_shift;
    logic [DATA_W-1:0]         sel_sample;
    logic                      in_addr_window;
    logic                      last_edge;

    // A cs_fall coinciding with a rising edge restarts the count first, so
    // that edge is treated as frame edge 0.
    always_comb begin
        cnt_eff        = cs_fall ? '0 : bit_cnt;
        in_addr_window = (int'(cnt_eff) >= ADC_ADDR_FIRST) &&
                         (int'(cnt_eff) <  ADC_ADDR_FIRST + ADC_ADDR_W);
        last_edge      = (int'(cnt_eff) == ADC_FRAME_BITS - 1);
        // After rising edge n, bit_cnt = n+1, so bit 14-n is bit 15-bit_cnt.
        tx_idx         = ADC_CNT_W'(ADC_FRAME_BITS - 1) - bit_cnt;
    end

    // Out-of-range channel addresses fall through with zero data.
    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(addr_latched) == i) sel_sample = sample_data[i];
        end
    end

    always_ff @(posedge c50m) begin
        if (rst) begin
            bit_cnt      <= '0;
            tx_word      <= '0;
            addr_shift   <= '0;
            addr_latched <= '0;
            dout         <= 1'b0;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (cs_n) begin
                dout <= 1'b0;
                if (bit_cnt != '0) begin
                    frame_abort <= 1'b1;
                    bit_cnt     <= '0;
                end
            end else begin
                if (cs_fall) begin
                    bit_cnt <= '0;
                    dout    <= 1'b0;
                end
                if (sclk_rise) begin
                    bit_cnt <= cnt_eff + 1'b1;
                    if (cnt_eff == '0) begin
                        tx_word <= ADC_FRAME_BITS'(sel_sample);
                    end
                    if (in_addr_window) begin
                        addr_shift <= {addr_shift[ADC_ADDR_W-2:0], din};
                    end
                    if (last_edge) begin
                        frame_done   <= 1'b1;
                        addr_latched <= addr_shift;
                    end
                end else if (sclk_fall && !cs_fall) begin
                    // bit_cnt == 0 here means either no edge yet or edge 15 done.
                    dout <= (bit_cnt != '0) ? tx_word[tx_idx] : 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - directed scoreboard bench for adc_spi_responder
module tb_adc_spi_responder;

    localparam int NCH    = 6;
    localparam int HALF_P = 25;

    logic                 c50m;
    logic                 rst;
    logic                 sclk_in;
    logic                 cs_n_in;
    logic                 din_in;
    logic [NCH-1:0][11:0] sample_data;
    logic                 dout;
    logic [2:0]           addr_latched;
    logic                 frame_done;
    logic                 frame_abort;

    int checks;
    int failures;
    int done_cnt;
    int abort_cnt;
    int done_exp;
    logic [2:0]  model_addr;
    logic [15:0] exp_q[$];

    adc_spi_responder #(.NUM_CH(NCH), .DATA_W(12), .SYNC_STAGES(2)) dut (
        .c50m(c50m), .rst(rst), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
        .din_in(din_in), .sample_data(sample_data), .dout(dout),
        .addr_latched(addr_latched), .frame_done(frame_done),
        .frame_abort(frame_abort)
    );

    initial begin
        c50m = 1'b0;
        forever #10 c50m = ~c50m;
    end

    always @(negedge c50m) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] expected_word(input logic [2:0] a);
        if (int'(a) < NCH) return {4'b0000, sample_data[a]};
        return 16'h0000;
    endfunction

    // Controller side: CPOL=0, dout sampled as SCLK rises, DIN changed while low.
    task automatic spi_edges(input logic [2:0] addr, input int n,
                             input bit chg_en, input logic [11:0] chg_val,
                             output logic [15:0] rx);
        rx = '0;
        for (int k = 0; k < n; k++) begin
            din_in = (k >= 2 && k <= 4) ? addr[4-k] : 1'b0;
            if (chg_en && k == 8) sample_data[2] = chg_val;
            repeat (HALF_P) @(negedge c50m);
            sclk_in   = 1'b1;
            rx[15-k]  = dout;
            repeat (HALF_P) @(negedge c50m);
            sclk_in   = 1'b0;
        end
    endtask

    task automatic full_frame(input logic [2:0] addr, input bit chg_en, input logic [11:0] chg_val);
        logic [15:0] rx;
        logic [15:0] want;
        exp_q.push_back(expected_word(model_addr));
        spi_edges(addr, 16, chg_en, chg_val, rx);
        repeat (10) @(negedge c50m);
        want = exp_q.pop_front();
        check("frame_data", {16'h0, rx}, {16'h0, want});
        model_addr = addr;
        done_exp++;
        check("addr_latched", {29'h0, addr_latched}, {29'h0, addr});
        check("frame_done_cnt", done_cnt, done_exp);
    endtask

    initial begin
        logic [15:0] scratch;
        checks = 0; failures = 0; done_cnt = 0; abort_cnt = 0; done_exp = 0;
        model_addr = 3'd0;
        rst = 1'b1; sclk_in = 1'b0; cs_n_in = 1'b1; din_in = 1'b0;
        sample_data[0] = 12'hABC;
        sample_data[1] = 12'h5A5;
        sample_data[2] = 12'h246;
        sample_data[3] = 12'h3C5;
        sample_data[4] = 12'h0F0;
        sample_data[5] = 12'h123;
        repeat (5) @(negedge c50m);
        check("rst_dout",         {31'h0, dout},        32'h0);
        check("rst_addr_latched", {29'h0, addr_latched}, 32'h0);
        check("rst_frame_done",   {31'h0, frame_done},  32'h0);
        check("rst_frame_abort",  {31'h0, frame_abort}, 32'h0);
        rst = 1'b0;
        cs_n_in = 1'b0;
        repeat (10) @(negedge c50m);

        full_frame(3'd5, 1'b0, 12'h0);     // returns channel 0 after reset
        full_frame(3'd7, 1'b0, 12'h0);     // returns channel 5, back-to-back
        full_frame(3'd2, 1'b0, 12'h0);     // address 7 >= NUM_CH returns zero
        full_frame(3'd2, 1'b1, 12'h777);   // channel 2 changed mid-frame
        full_frame(3'd3, 1'b0, 12'h0);     // now sees the new channel 2 value

        spi_edges(3'd6, 7, 1'b0, 12'h0, scratch);
        repeat (5) @(negedge c50m);
        cs_n_in = 1'b1;
        repeat (10) @(negedge c50m);
        check("abort_cnt",          abort_cnt, 1);
        check("abort_addr_latched", {29'h0, addr_latched}, {29'h0, model_addr});
        check("abort_dout",         {31'h0, dout}, 32'h0);
        check("abort_no_done",      done_cnt, done_exp);
        cs_n_in = 1'b0;
        repeat (10) @(negedge c50m);
        full_frame(3'd1, 1'b0, 12'h0);     // clean frame after abort, channel 3

        spi_edges(3'd4, 9, 1'b0, 12'h0, scratch);
        rst = 1'b1;
        sclk_in = 1'b1;
        @(negedge c50m);
        check("midrst_dout",         {31'h0, dout},         32'h0);
        check("midrst_addr_latched", {29'h0, addr_latched}, 32'h0);
        check("midrst_frame_done",   {31'h0, frame_done},   32'h0);
        check("midrst_frame_abort",  {31'h0, frame_abort},  32'h0);
        sclk_in = 1'b0;
        @(negedge c50m);
        rst = 1'b0;
        model_addr = 3'd0;
        repeat (10) @(negedge c50m);
        full_frame(3'd4, 1'b0, 12'h0);     // channel 0 after mid-frame reset
        check("final_abort_cnt", abort_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable model of the 8-channel, 12-bit serial ADC as seen from its pins: the SPI responder that the ADC control logic talks to. It samples SCLK, CS_n and DIN with a fast system clock, decodes the 3-bit channel address, and shifts back a 16-bit frame of 4 zeros plus the 12-bit sample for the channel addressed in the previous frame. Used for board-level loopback and hardware-in-loop testing of the data-gathering path, with channel values supplied by fabric logic.

## Interface
- `NUM_CH`, default 8: channels served; address width is fixed at 3.
- `DATA_W`, default 12: sample width.
- `SYNC_STAGES`, default 2: synchronizer depth on the pin inputs, minimum 2.
- `c50m` in 1: system clock, ≥ 16× SCLK frequency. One clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `sclk_in` in 1: SPI clock from the controller, asynchronous.
- `cs_n_in` in 1: chip select, active low, asynchronous; may be held low permanently.
- `din_in` in 1: controller data (address bits), asynchronous.
- `sample_data` in `[NUM_CH-1:0][DATA_W-1:0]`: value to return per channel, sampled in the `c50m` domain.
- `dout` out 1: responder data to the controller.
- `addr_latched` out 3: channel address decoded in the last completed frame.
- `frame_done` out 1: one-cycle pulse when a frame's 16th SCLK rising edge is seen.
- `frame_abort` out 1: one-cycle pulse when CS_n rises mid-frame.

## Operation
- `sclk_in`, `cs_n_in` and `din_in` pass through `SYNC_STAGES` flops, then registered edge detection: `sclk_rise`, `sclk_fall` and `cs_fall`. `din` uses the same delay as `sclk`, so it is aligned with the detected edges.
- Frame counter `bit_cnt[3:0]` counts SCLK rising edges in the frame, 0 to 15. A rising edge at 15 wraps it to 0, pulses `frame_done`, and loads `addr_latched` from `addr_shift`.
- With CS_n held low, frames run back-to-back, bounded only by the 16-edge count.
- `cs_fall` resets `bit_cnt` to 0 and forces `dout`=0.
- CS_n high with `bit_cnt`≠0 aborts the frame: pulse `frame_abort`, `bit_cnt`←0, `addr_latched` unchanged, `dout` held 0.
- While CS_n is synchronized high, all edges are ignored.
- Address capture: on the rising edge with `bit_cnt` = 2, 3 or 4, `din` shifts into `addr_shift` as ADD2, ADD1, ADD0, MSB first.
- Addresses ≥ `NUM_CH` are latched as-is. The returned data is then 0.
- Data snapshot: on the rising edge with `bit_cnt`=0, `tx_word` ← `{4'b0, sample_data[addr_latched]}`. This is the previous frame's address; after reset it is channel 0.
- Output: on each falling edge following rising edge n (n = 0..14), `dout` ← `tx_word[14-n]`. DB11 is therefore valid at rising edge 4 and DB0 at rising edge 15.
- On the falling edge following rising edge 15, `dout` ← 0.
- Simultaneous `cs_fall` and `sclk_rise` in the same cycle: `cs_fall` first, then the edge counts as rising edge 0.
- `rst` mid-frame: everything returns to its reset value at once. The next counted edge is frame edge 0.

## Timing
- Reset values: `dout`=0, `addr_latched`=0, `frame_done`=0, `frame_abort`=0, `bit_cnt`=0, `tx_word`=0.
- Pin-to-detected-edge latency is `SYNC_STAGES`+1 `c50m` cycles.
- `dout` updates one cycle after `sclk_fall` is detected: 4 cycles after the pin edge with the defaults. This must be < half an SCLK period (25 cycles at 1 MHz SCLK / 50 MHz clock).
- `frame_done` and the `addr_latched` update happen in the same cycle, one cycle after the 16th `sclk_rise` is detected.
- `sample_data` is sampled only in the snapshot cycle. Changes at any other time do not affect the frame in progress.

## Structure
- Package `adc_pkg`:
  - `ADC_FRAME_BITS`=16, `ADC_ADDR_W`=3, `ADC_ADDR_FIRST`=2, `ADC_LEAD_ZEROS`=4.
  - typedef `adc_sample_t` (logic [11:0]), typedef `adc_addr_t` (logic [2:0]).
- Sub-module `pin_sync_edge`: parameterized synchronizer plus registered rise/fall detect, instantiated once each for SCLK, CS_n and DIN.
- The frame counter, address shifter and output shifter stay in the top module.

## Test plan
- Reset, CS_n low, 16 SCLK at 1 MHz with DIN address 3'b101, channel 0 = 12'hABC. Response: `dout` = 0000_1010_1011_1100; `addr_latched`=5 after `frame_done`.
- Next frame with channel 5 = 12'h123, CS_n still low. Response: `dout` = 0x0123 over the 16 rising edges, proving continuous framing and the one-frame address pipeline.
- Address 3'b111 with `NUM_CH`=6. Response: the following frame returns 0x0000 and `addr_latched`=7.
- CS_n rises after 7 SCLK. Response: `frame_abort` pulses once, `addr_latched` unchanged, `dout`=0; the next CS_n fall starts a clean frame at edge 0.
- `rst` asserted at edge 9. Response: all outputs 0 on the next cycle; the following 16 edges form a frame returning channel 0.
- Change `sample_data` mid-frame, after the snapshot. Response: the current frame still returns the old value; the next frame returns the new one.
